// File: rtl/amp_ltc6912_pkg.sv
// Shared definitions for the LTC6912-1 pre-amp controller: FSM states,
// gain codes and the 8-bit gain word layout (A nibble high, B nibble low).
package amp_ltc6912_pkg;

  typedef enum logic [2:0] {
    ST_SHDN_HI,
    ST_SHDN_LO,
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam int GAIN_W = 4;
  localparam int WORD_W = 8;
  localparam int A_MSB  = 7;
  localparam int A_LSB  = 4;
  localparam int B_MSB  = 3;
  localparam int B_LSB  = 0;

  localparam logic [GAIN_W-1:0] GAIN_0    = 4'd0;
  localparam logic [GAIN_W-1:0] GAIN_M1   = 4'd1;
  localparam logic [GAIN_W-1:0] GAIN_M2   = 4'd2;
  localparam logic [GAIN_W-1:0] GAIN_M5   = 4'd3;
  localparam logic [GAIN_W-1:0] GAIN_M10  = 4'd4;
  localparam logic [GAIN_W-1:0] GAIN_M20  = 4'd5;
  localparam logic [GAIN_W-1:0] GAIN_M50  = 4'd6;
  localparam logic [GAIN_W-1:0] GAIN_M100 = 4'd7;

  function automatic logic [WORD_W-1:0] pack_gain(input logic [GAIN_W-1:0] a,
                                                  input logic [GAIN_W-1:0] b);
    logic [WORD_W-1:0] w;
    w = '0;
    w[A_MSB:A_LSB] = a;
    w[B_MSB:B_LSB] = b;
    return w;
  endfunction

endpackage

// File: rtl/amp_ltc6912_if.sv
// Host-side request/response bundle for the pre-amp controller.
interface amp_ltc6912_if;
  import amp_ltc6912_pkg::*;

  logic              start;
  logic [GAIN_W-1:0] gain_a;
  logic [GAIN_W-1:0] gain_b;
  logic              ready;
  logic              done;
  logic [WORD_W-1:0] rdata;

  modport master (output start, gain_a, gain_b, input ready, done, rdata);
  modport slave  (input start, gain_a, gain_b, output ready, done, rdata);

endinterface

// File: rtl/amp_ltc6912_spi_sck_tick.sv
// SCK half-period generator: phase_end marks the last cycle of each half
// period, and sck_level toggles there. Held at zero while disabled.
module spi_sck_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic phase_end,
  output logic sck_level
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      cnt       <= '0;
      sck_level <= 1'b0;
    end else if (phase_end) begin
      cnt       <= '0;
      sck_level <= ~sck_level;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/amp_ltc6912_ctrl.sv
// SPI master for the LTC6912-1: shutdown pulse after reset, then one 8-bit
// gain write per start with simultaneous readback of the previous word.
module amp_ltc6912_ctrl
  import amp_ltc6912_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 2,
  parameter int SHDN_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RST,
  amp_ltc6912_if.slave       bus,
  output logic               SPI_SCK,
  output logic               SPI_MOSI,
  output logic               AMP_CS,
  output logic               AMP_SHDN,
  input  logic               AMP_DOUT
);

  localparam int CNT_MAX = (CS_SETUP > SHDN_CYCLES) ? CS_SETUP : SHDN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [WORD_W-1:0] tx, tx_n;
  logic [WORD_W-1:0] rx, rx_n;
  logic [3:0]        bit_cnt, bit_n;
  logic [WORD_W-1:0] rdata_q, rdata_n;

  logic sck_en, phase_end, sck_level;
  logic cs_c, shdn_c, mosi_c, ready_c, done_c;

  spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK       (CLK),
    .RST       (RST),
    .en        (sck_en),
    .phase_end (phase_end),
    .sck_level (sck_level)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_SHDN_HI;
      cnt     <= '0;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tx      <= tx_n;
      rx      <= rx_n;
      bit_cnt <= bit_n;
      rdata_q <= rdata_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    tx_n    = tx;
    rx_n    = rx;
    bit_n   = bit_cnt;
    rdata_n = rdata_q;
    sck_en  = 1'b0;
    cs_c    = 1'b1;
    shdn_c  = 1'b0;
    mosi_c  = 1'b0;
    ready_c = 1'b0;
    done_c  = 1'b0;

    case (state)
      ST_SHDN_HI: begin
        shdn_c = 1'b1;
        if (cnt == CNT_W'(SHDN_CYCLES - 1)) begin
          state_n = ST_SHDN_LO;
          cnt_n   = '0;
        end
      end
      ST_SHDN_LO: begin
        if (cnt == CNT_W'(SHDN_CYCLES - 1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      ST_IDLE: begin
        ready_c = 1'b1;
        cnt_n   = '0;
        if (bus.start) begin
          tx_n    = pack_gain(bus.gain_a, bus.gain_b);
          state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cs_c   = 1'b0;
        mosi_c = tx[WORD_W-1];
        if (cnt == CNT_W'(CS_SETUP - 1)) begin
          state_n = ST_SHIFT;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      // Sample DOUT just before the falling edge, which is also where the
      // next MOSI bit is presented.
      ST_SHIFT: begin
        cs_c   = 1'b0;
        mosi_c = tx[WORD_W-1];
        sck_en = 1'b1;
        cnt_n  = '0;
        if (phase_end && sck_level) begin
          rx_n  = {rx[WORD_W-2:0], AMP_DOUT};
          tx_n  = {tx[WORD_W-2:0], 1'b0};
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        cs_c   = 1'b0;
        mosi_c = tx[WORD_W-1];
        if (cnt == CNT_W'(CS_SETUP - 1)) begin
          state_n = ST_DONE;
          cnt_n   = '0;
          rdata_n = rx;
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        ready_c = 1'b1;
        cnt_n   = '0;
        if (bus.start) begin
          tx_n    = pack_gain(bus.gain_a, bus.gain_b);
          state_n = ST_SETUP;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_SHDN_HI;
        cnt_n   = '0;
      end
    endcase
  end

  assign SPI_SCK   = sck_level;
  assign SPI_MOSI  = mosi_c;
  assign AMP_CS    = cs_c;
  assign AMP_SHDN  = shdn_c;
  assign bus.ready = ready_c;
  assign bus.done  = done_c;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_amp_ltc6912_ctrl.sv
// Directed bench for amp_ltc6912_ctrl with a small LTC6912 shift-register
// model that returns the previously latched gain word on AMP_DOUT.
module tb_amp_ltc6912_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SPI_SCK, SPI_MOSI, AMP_CS, AMP_SHDN, AMP_DOUT;

  amp_ltc6912_if bus ();

  amp_ltc6912_ctrl #(.CLK_DIV(4), .CS_SETUP(2), .SHDN_CYCLES(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .SPI_SCK  (SPI_SCK),
    .SPI_MOSI (SPI_MOSI),
    .AMP_CS   (AMP_CS),
    .AMP_SHDN (AMP_SHDN),
    .AMP_DOUT (AMP_DOUT)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Amp model: MOSI captured on SCK rise, shifted in on SCK fall, DOUT is
  // the MSB of the register, which starts each frame with the latched word.
  logic [7:0] sr = 8'h00;
  logic [7:0] latched = 8'h00;
  logic       mbit = 1'b0;
  logic       p_cs = 1'b1, p_sck = 1'b0, p_shdn = 1'b0;
  int         bits = 0;
  int         blad_cnt = 0;

  assign AMP_DOUT = sr[7];

  always @(SPI_SCK or AMP_CS or AMP_SHDN) begin
    if (AMP_SHDN === 1'b1 && p_shdn !== 1'b1) latched = 8'h00;
    if (AMP_CS === 1'b0 && p_cs === 1'b1) begin
      sr   = latched;
      bits = 0;
    end
    if (AMP_CS === 1'b1 && p_cs === 1'b0) begin
      if (bits == 8) latched = sr;
      else blad_cnt++;
    end
    if (SPI_SCK === 1'b1 && p_sck === 1'b0) begin
      mbit = SPI_MOSI;
      bits++;
    end
    if (SPI_SCK === 1'b0 && p_sck === 1'b1) sr = {sr[6:0], mbit};
    p_cs   = AMP_CS;
    p_sck  = SPI_SCK;
    p_shdn = AMP_SHDN;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Called on the first cycle after the last reset edge.
  task automatic check_powerup(input string tag);
    for (int i = 0; i <= 8; i++) begin
      check_output($sformatf("%s_shdn%0d", tag, i), AMP_SHDN, (i < 4) ? 1 : 0);
      check_output($sformatf("%s_ready%0d", tag, i), bus.ready, (i == 8) ? 1 : 0);
      check_output($sformatf("%s_done%0d", tag, i), bus.done, 0);
      check_output($sformatf("%s_cs%0d", tag, i), AMP_CS, 1);
      if (i < 8) tick();
    end
  endtask

  // Sample 0 is the cycle where start is driven; done is due on sample 69.
  task automatic apply_stimulus(input string tag, input logic [3:0] ga, input logic [3:0] gb,
                                input logic [7:0] exp_rd, input bit pre_started,
                                input bit mid_starts, input bit chain,
                                input logic [3:0] ca, input logic [3:0] cb);
    int done_at = 0, cs_low = 0, cs_falls = 0, rises = 0, first_rise = 0;
    int last_chg = 0, min_setup = 1000, mosi_bad = 0;
    logic prev_cs, prev_sck, prev_mosi;
    logic [7:0] word = 8'h00;
    bit seen = 0;
    if (!pre_started) begin
      bus.start  = 1'b1;
      bus.gain_a = ga;
      bus.gain_b = gb;
    end
    prev_cs   = AMP_CS;
    prev_sck  = SPI_SCK;
    prev_mosi = SPI_MOSI;
    for (int n = 1; n <= 150 && !seen; n++) begin
      tick();
      bus.start = mid_starts && (n == 10 || n == 40);
      if (bus.start) begin
        bus.gain_a = 4'hF;
        bus.gain_b = 4'hF;
      end
      if (AMP_CS === 1'b0) cs_low++;
      if (prev_cs === 1'b1 && AMP_CS === 1'b0) cs_falls++;
      if (SPI_MOSI !== prev_mosi) begin
        last_chg = n;
        if (SPI_SCK === 1'b1) mosi_bad++;
      end
      if (prev_sck === 1'b0 && SPI_SCK === 1'b1) begin
        rises++;
        if (rises == 1) first_rise = n;
        word = {word[6:0], SPI_MOSI};
        if (n - last_chg < min_setup) min_setup = n - last_chg;
      end
      if (bus.done === 1'b1) begin
        seen    = 1;
        done_at = n;
        check_output({tag, "_cs_at_done"}, AMP_CS, 1);
        check_output({tag, "_ready_at_done"}, bus.ready, 1);
        check_output({tag, "_rdata"}, bus.rdata, exp_rd);
        if (chain) begin
          bus.start  = 1'b1;
          bus.gain_a = ca;
          bus.gain_b = cb;
        end
      end
      prev_cs   = AMP_CS;
      prev_sck  = SPI_SCK;
      prev_mosi = SPI_MOSI;
    end
    check_output({tag, "_done_seen"}, seen, 1);
    check_output({tag, "_done_at"}, done_at, 69);
    check_output({tag, "_cs_low_cycles"}, cs_low, 68);
    check_output({tag, "_cs_falls"}, cs_falls, 1);
    check_output({tag, "_sck_rises"}, rises, 8);
    check_output({tag, "_first_rise"}, first_rise, 7);
    check_output({tag, "_mosi_word"}, word, {ga, gb});
    check_output({tag, "_mosi_setup_ok"}, (min_setup >= 4) ? 1 : 0, 1);
    check_output({tag, "_mosi_while_sck_hi"}, mosi_bad, 0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.gain_a = 4'h0;
    bus.gain_b = 4'h0;

    // Power-up: three reset cycles, then the shutdown pulse and quiet time.
    tick();
    check_output("rst_sck", SPI_SCK, 0);
    check_output("rst_mosi", SPI_MOSI, 0);
    check_output("rst_cs", AMP_CS, 1);
    check_output("rst_shdn", AMP_SHDN, 1);
    check_output("rst_ready", bus.ready, 0);
    check_output("rst_done", bus.done, 0);
    check_output("rst_rdata", bus.rdata, 8'h00);
    tick();
    tick();
    RST = 1'b0;
    check_powerup("pwr");

    apply_stimulus("f1", 4'd1, 4'd1, 8'h00, 0, 0, 0, 4'd0, 4'd0);
    apply_stimulus("f2", 4'd3, 4'd2, 8'h11, 0, 0, 0, 4'd0, 4'd0);
    apply_stimulus("f3", 4'd7, 4'd1, 8'h32, 0, 1, 1, 4'd4, 4'd4);
    apply_stimulus("f4", 4'd4, 4'd4, 8'h71, 1, 0, 0, 4'd0, 4'd0);
    check_output("blad_before_abort", blad_cnt, 0);

    // Abort a transfer with reset on its cycle 30.
    bus.start  = 1'b1;
    bus.gain_a = 4'd2;
    bus.gain_b = 4'd5;
    for (int n = 1; n <= 30; n++) begin
      tick();
      bus.start = 1'b0;
      check_output($sformatf("abort_no_done%0d", n), bus.done, 0);
    end
    check_output("abort_cs_low_before", AMP_CS, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_output("abort_cs", AMP_CS, 1);
    check_output("abort_sck", SPI_SCK, 0);
    check_output("abort_shdn", AMP_SHDN, 1);
    check_output("abort_rdata", bus.rdata, 8'h00);
    check_powerup("repwr");
    check_output("abort_rdata_after", bus.rdata, 8'h00);
    check_output("blad_after_abort", blad_cnt, 1);

    // Boundary gain codes after the amp was reset by the shutdown pulse.
    apply_stimulus("f6", 4'd0, 4'd15, 8'h00, 0, 0, 0, 4'd0, 4'd0);
    apply_stimulus("f7", 4'd8, 4'd7, 8'h0F, 0, 0, 0, 4'd0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/amp_ltc6912_ctrl.md
# amp_ltc6912_ctrl

SPI master that programs the LTC6912-1 dual programmable pre-amplifier in front of the ADC on the Spartan-3 board. After reset it issues the mandatory AMP_SHDN pulse, then on each `start` shifts one 8-bit gain word (A nibble first, MSB first) out on SPI_MOSI with AMP_CS low. In the same transfer it captures the previous gain word that the amp shifts back on AMP_DOUT. It drives the amp pins directly and is exercised against the AmpLTC6912_1_behav model.

## Interface
- `CLK_DIV`, 4: system cycles per SCK half-period; must be ≥1. The default gives 6.25 MHz SCK at 50 MHz.
- `CS_SETUP`, 2: cycles between AMP_CS falling and the first SCK rise, and between the last SCK fall and AMP_CS rising. Must be ≥2 (≥30 ns).
- `SHDN_CYCLES`, 4: AMP_SHDN high time and post-SHDN quiet time after reset; must be ≥1.
- `CLK  in  1`: system clock; every register is clocked on its rising edge.
- `RST  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle request; accepted only while `ready`=1.
- `gain_a  in  4`: gain code for amp A; sampled when start is accepted.
- `gain_b  in  4`: gain code for amp B; sampled when start is accepted.
- `ready  out  1`: idle and able to accept start.
- `done  out  1`: one-cycle pulse at the end of a transfer.
- `rdata  out  8`: previous gain word read back from AMP_DOUT; updated at `done`.
- `SPI_SCK  out  1`: SPI clock to the amp.
- `SPI_MOSI  out  1`: serial data to the amp.
- `AMP_CS  out  1`: amp chip select, active low.
- `AMP_SHDN  out  1`: amp shutdown/reset.
- `AMP_DOUT  in  1`: serial readback from the amp.

## Operation
- Reset values: SPI_SCK=0, SPI_MOSI=0, AMP_CS=1, AMP_SHDN=1, ready=0, done=0, rdata=0x00. State is SHDN_HI with the counter cleared.
- States and transitions:
  - SHDN_HI: AMP_SHDN=1 for SHDN_CYCLES cycles, then go to SHDN_LO.
  - SHDN_LO: AMP_SHDN=0 and AMP_CS=1 for SHDN_CYCLES cycles, then go to IDLE.
  - IDLE: ready=1. On start, latch `{gain_a,gain_b}` into the TX shift register and go to SETUP.
  - SETUP: AMP_CS=0, SCK=0, MOSI=tx[7] for CS_SETUP cycles, then go to SHIFT.
  - SHIFT: run 8 bits. Each bit is CLK_DIV cycles with SCK=0 followed by CLK_DIV cycles with SCK=1.
    - On the last high-phase cycle of each bit, shift AMP_DOUT into the RX register (MSB first).
    - On each SCK fall, shift TX left so MOSI presents the next bit.
    - A 4-bit bit counter ends the state after bit index 7.
  - HOLD: SCK=0, AMP_CS=0 for CS_SETUP cycles, then go to DONE.
  - DONE: AMP_CS=1, done=1, rdata←RX, ready=1, MOSI=0; then go to IDLE.
- `start` outside IDLE/DONE is ignored; there is no queueing. `start` in the DONE cycle is accepted exactly as in IDLE.
- Gain codes are forwarded unmodified, including 0 and 8–15. Range checking belongs to the amp model.
- AMP_SHDN stays 0 in every state after SHDN_LO.

## Timing
- Power-up: ready first rises 2·SHDN_CYCLES cycles after the last RST cycle (8 by default).
- Transfer, with start accepted at cycle 0:
  - AMP_CS is low from cycle 1 through cycle N = 2·CS_SETUP + 16·CLK_DIV (68 by default).
  - done=1 on cycle N+1, the same cycle AMP_CS returns high.
- The first SCK rise occurs at cycle CS_SETUP + CLK_DIV + 1.
- MOSI only changes while SCK=0, and is stable for ≥CLK_DIV cycles before each rise.
- SCK is exactly 8 rising edges per CS-low window, and is low whenever AMP_CS toggles.
- RST mid-transfer: on the next edge AMP_CS=1, SCK=0 and AMP_SHDN=1, and the full SHDN sequence reruns. No done pulse is issued and rdata is unchanged (reset value).

## Structure
- Shared package `amp_ltc6912_pkg` holds:
  - state encodings;
  - gain-code constants (GAIN_M1=4'd1 … GAIN_M100=4'd7);
  - the word layout (A in [7:4], B in [3:0]).
- One sub-module, `spi_sck_tick`, provides a CLK_DIV half-period counter with `phase_end` and `sck_level` outputs; it is enabled only in SHIFT.
- The FSM, shift registers and bit counter live in the top module.

## Test plan
- Power-up: RST high for 3 cycles → AMP_SHDN=1 until 4 cycles after release, then 0; ready=1 at cycle 8; the model prints the reset messages with no BLAD line.
- Write gain_a=1, gain_b=1 → MOSI bit stream 0x11, exactly 8 SCK rises, done at cycle 69; the model reports A and B in the 0.4–2.9 V range.
- Second write 3/2 → MOSI 0x32 and rdata=0x11 at done.
- Pulse start on cycles 10 and 40 of a transfer → exactly one transfer; AMP_CS falls only once.
- start asserted in the DONE cycle with gains 4/4 → the next CS-low window begins on the following cycle; rdata=previous word.
- Assert RST at cycle 30 of a transfer → AMP_CS=1 on the next edge, no done pulse, SHDN sequence repeats; the model reports a bit-count BLAD for the aborted frame.
